sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/mem_pkg.sv | 15 +
 rtl/sram_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_sram_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM controller: FSM state encoding and default strobe length.
package mem_pkg;

    localparam int unsigned WAIT_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage : mem_pkg

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: single-word read/write with a fixed-length strobe.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req, req_we, req_addr,    initiator request (level, held until ack), byte
//   req_wdata, req_be         address, write data and byte-lane enables
//   ack, rdata, busy          completion pulse, read word, non-idle flag
//   sram_addr, sram_dq_i/o,   SRAM word address, data in/out, data drive enable
//   sram_dq_oe, sram_*_n      active-low chip/output/write/lane strobes
module sram_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [31:0]       sram_dq_i,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_be;
    logic               r_ack;
    logic               r_busy;
    logic [31:0]        r_rdata;
    logic [ADDR_W-1:0]  r_sram_addr;
    logic [31:0]        r_sram_dq_o;
    logic               r_sram_dq_oe;
    logic               r_sram_ce_n;
    logic               r_sram_oe_n;
    logic               r_sram_we_n;
    logic [3:0]         r_sram_be_n;

    state_t             w_state_n;
    logic [CNT_W-1:0]   w_cnt_n;
    logic [3:0]         w_be_n;
    logic               w_ack_n;
    logic               w_busy_n;
    logic [31:0]        w_rdata_n;
    logic [ADDR_W-1:0]  w_addr_n;
    logic [31:0]        w_dq_o_n;
    logic               w_dq_oe_n;
    logic               w_ce_n_n;
    logic               w_oe_n_n;
    logic               w_we_n_n;
    logic [3:0]         w_lane_n_n;

    // Byte-offset bits and bits above the SRAM word range are not used.
    logic w_unused_addr;
    assign w_unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    // State register plus registered copies of every output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_be         <= '0;
            r_ack        <= 1'b0;
            r_busy       <= 1'b0;
            r_rdata      <= '0;
            r_sram_addr  <= '0;
            r_sram_dq_o  <= '0;
            r_sram_dq_oe <= 1'b0;
            r_sram_ce_n  <= 1'b1;
            r_sram_oe_n  <= 1'b1;
            r_sram_we_n  <= 1'b1;
            r_sram_be_n  <= 4'hF;
        end else begin
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            r_be         <= w_be_n;
            r_ack        <= w_ack_n;
            r_busy       <= w_busy_n;
            r_rdata      <= w_rdata_n;
            r_sram_addr  <= w_addr_n;
            r_sram_dq_o  <= w_dq_o_n;
            r_sram_dq_oe <= w_dq_oe_n;
            r_sram_ce_n  <= w_ce_n_n;
            r_sram_oe_n  <= w_oe_n_n;
            r_sram_we_n  <= w_we_n_n;
            r_sram_be_n  <= w_lane_n_n;
        end
    end

    // Next state, request latching and next output values. Outputs are derived
    // from the next state so the registered pins line up with the state they describe.
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_be_n     = r_be;
        w_rdata_n  = r_rdata;
        w_addr_n   = r_sram_addr;
        w_dq_o_n   = r_sram_dq_o;
        w_ack_n    = 1'b0;
        w_dq_oe_n  = 1'b0;
        w_ce_n_n   = 1'b1;
        w_oe_n_n   = 1'b1;
        w_we_n_n   = 1'b1;
        w_lane_n_n = 4'hF;

        unique case (r_state)
            IDLE: begin
                if (req) begin
                    w_addr_n = req_addr[ADDR_W+1:2];
                    w_cnt_n  = '0;
                    if (req_we) begin
                        w_be_n    = req_be;
                        w_dq_o_n  = req_wdata;
                        w_state_n = WR_SETUP;
                    end else begin
                        w_state_n = RD;
                    end
                end
            end
            RD: begin
                if (r_cnt == CNT_LAST) begin
                    w_rdata_n = sram_dq_i;
                    w_state_n = DONE;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            WR_SETUP: begin
                w_cnt_n   = '0;
                w_state_n = WR_PULSE;
            end
            WR_PULSE: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_n = WR_HOLD;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            WR_HOLD:  w_state_n = DONE;
            DONE:     w_state_n = IDLE;
            default:  w_state_n = IDLE;
        endcase

        w_busy_n = (w_state_n != IDLE);

        // Output enable and data drive are never produced by the same state.
        unique case (w_state_n)
            RD: begin
                w_ce_n_n   = 1'b0;
                w_oe_n_n   = 1'b0;
                w_lane_n_n = 4'h0;
            end
            WR_SETUP, WR_HOLD: begin
                w_ce_n_n   = 1'b0;
                w_dq_oe_n  = 1'b1;
                w_lane_n_n = ~w_be_n;
            end
            WR_PULSE: begin
                w_ce_n_n   = 1'b0;
                w_dq_oe_n  = 1'b1;
                w_lane_n_n = ~w_be_n;
                // An all-lanes-off write never pulses we_n.
                w_we_n_n   = (w_be_n == 4'h0);
            end
            DONE:    w_ack_n = 1'b1;
            default: ;
        endcase
    end

    assign ack        = r_ack;
    assign busy       = r_busy;
    assign rdata      = r_rdata;
    assign sram_addr  = r_sram_addr;
    assign sram_dq_o  = r_sram_dq_o;
    assign sram_dq_oe = r_sram_dq_oe;
    assign sram_ce_n  = r_sram_ce_n;
    assign sram_oe_n  = r_sram_oe_n;
    assign sram_we_n  = r_sram_we_n;
    assign sram_be_n  = r_sram_be_n;

endmodule : sram_ctrl

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl (ADDR_W=20, WAIT_CYCLES=2): a cycle-accurate
// expected-output queue is built per transaction and drained against the DUT.
module tb_sram_ctrl;

    localparam int unsigned AW = 20;
    localparam int unsigned W  = 2;

    typedef struct packed {
        logic          ack;
        logic          busy;
        logic          ce_n;
        logic          oe_n;
        logic          we_n;
        logic [3:0]    be_n;
        logic          dq_oe;
        logic [AW-1:0] addr;
        logic [31:0]   dq_o;
        logic [31:0]   rdata;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          ack;
    logic [31:0]   rdata;
    logic          busy;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_dq_i = '0;
    logic [31:0]   sram_dq_o;
    logic          sram_dq_oe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [3:0]    sram_be_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference copies of the held registers.
    logic [AW-1:0] m_addr  = '0;
    logic [31:0]   m_dq_o  = '0;
    logic [31:0]   m_rdata = '0;

    sram_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .ack        (ack),
        .rdata      (rdata),
        .busy       (busy),
        .sram_addr  (sram_addr),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_be_n  (sram_be_n)
    );

    always #5 clk = ~clk;

    task automatic sample(output obs_t o);
        @(posedge clk);
        #1;
        o.ack   = ack;
        o.busy  = busy;
        o.ce_n  = sram_ce_n;
        o.oe_n  = sram_oe_n;
        o.we_n  = sram_we_n;
        o.be_n  = sram_be_n;
        o.dq_oe = sram_dq_oe;
        o.addr  = sram_addr;
        o.dq_o  = sram_dq_o;
        o.rdata = rdata;
    endtask

    function automatic obs_t mk(input logic a, input logic b, input logic ce,
                                input logic oe, input logic we,
                                input logic [3:0] ben, input logic doe);
        obs_t o;
        o.ack   = a;
        o.busy  = b;
        o.ce_n  = ce;
        o.oe_n  = oe;
        o.we_n  = we;
        o.be_n  = ben;
        o.dq_oe = doe;
        o.addr  = m_addr;
        o.dq_o  = m_dq_o;
        o.rdata = m_rdata;
        return o;
    endfunction

    // Drives one transaction from the current (accept) cycle and checks every
    // following cycle through the idle cycle after ack. With keep=1, req stays
    // high and req_addr moves to next_addr mid-transaction.
    task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] dq, input logic keep,
                           input logic [31:0] next_addr);
        obs_t exp_q[$];
        obs_t got;
        obs_t e;
        int   cyc;
        req       = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        sram_dq_i = dq;
        m_addr    = addr[AW+1:2];
        if (we) begin
            m_dq_o = wdata;
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, ~be, 1'b1));
            for (int i = 0; i < W; i++)
                exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, (be == 4'h0), ~be, 1'b1));
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, ~be, 1'b1));
        end else begin
            for (int i = 0; i < W; i++)
                exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0));
            m_rdata = dq;
        end
        exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0));
        cyc = 0;
        while (exp_q.size() > 0) begin
            sample(got);
            cyc++;
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s cyc%0d: got %h, expected %h", name, cyc, got, e);
            end
            if (cyc == 1) begin
                req_addr  = keep ? next_addr : ~addr;
                req_we    = ~we;
                req_wdata = ~wdata;
                req_be    = ~be;
            end
            if (e.ack && !keep) req = 1'b0;
        end
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t e;
        rst = 1'b1;
        sample(got);
        sample(got);
        m_addr = '0; m_dq_o = '0; m_rdata = '0;
        e = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0);
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset: got %h, expected %h", got, e);
        end
        rst = 1'b0;
        sample(got);
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_release: got %h, expected %h", got, e);
        end
    endtask

    task automatic test_read();
        run_txn("read", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 32'h0);
    endtask

    task automatic test_write();
        run_txn("write_full", 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0);
        run_txn("write_lane2", 1'b1, 32'h0000_0024, 32'h00AB_0000, 4'b0100, 32'h5555_5555, 1'b0, 32'h0);
        run_txn("write_no_be", 1'b1, 32'h0000_0028, 32'hA5A5_A5A5, 4'h0, 32'h0, 1'b0, 32'h0);
        run_txn("write_top_addr", 1'b1, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 4'b1001, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_first", 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1, 32'h0000_0080);
        run_txn("b2b_second", 1'b0, 32'h0000_0080, 32'h0, 4'h0, 32'h0BAD_C0DE, 1'b0, 32'h0);
        // A read after writes must still see the preceding write data held on dq_o.
        run_txn("read_after", 1'b0, 32'h0003_FFFC, 32'h0, 4'h0, 32'h8765_4321, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_write();
        obs_t got;
        obs_t e;
        req       = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0100;
        req_wdata = 32'h7777_8888;
        req_be    = 4'b0011;
        m_addr    = 20'h00040;
        m_dq_o    = 32'h7777_8888;
        sample(got);
        e = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b1);
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL rst_mid_setup: got %h, expected %h", got, e);
        end
        sample(got);
        e = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1100, 1'b1);
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL rst_mid_pulse: got %h, expected %h", got, e);
        end
        rst = 1'b1;
        req = 1'b0;
        sample(got);
        m_addr = '0; m_dq_o = '0; m_rdata = '0;
        e = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0);
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL rst_mid_abort: got %h, expected %h", got, e);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample(got);
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL rst_mid_quiet%0d: got %h, expected %h", i, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_mid_write();
        test_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sram_ctrl
